rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource (a single datapath or bus slot) among requesters. It registers a one-hot grant plus the encoded owner ID, holds the grant until the owner releases, then rotates priority past the last owner so no requester starves. Internally, a rotated priority encoder selects the next owner.

## Interface
Parameters:
- MAX_HOLD, 16: maximum consecutive BUSY cycles per grant; used only with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req  in  4  request vector; bit i = requester i wants the resource; level-sensitive.
- done  in  1  owner release strobe; meaningful only while busy=1.
- gnt  out  4  registered one-hot grant; all-zero when idle.
- gnt_id  out  2  binary index of the current owner; holds its last value when idle.
- busy  out  1  1 while a grant is held.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit; constant 0 without ARB_TIMEOUT_EN.

## Operation
- States: IDLE, BUSY.
- IDLE behaviour:
  - If req==0, stay in IDLE.
  - Otherwise, search req starting at index ptr+1 mod 4 and moving upward with wrap; the first set bit wins.
  - Register gnt=onehot(win), gnt_id=win, busy=1, ptr=win; go to BUSY.
- BUSY behaviour:
  - Release when done=1 or req[gnt_id]=0.
  - On release: gnt=0, busy=0, go to IDLE. gnt_id and ptr are retained.
  - Otherwise hold all outputs.
- Re-arbitration happens only in IDLE, so there is exactly one idle cycle between consecutive grants.
- Requests that arrive while BUSY wait; nothing is queued beyond the level of req.
- Reset values: gnt=0000, gnt_id=00, busy=0, timeout=0, ptr=3, state=IDLE. Because ptr=3, the first search order after reset is 0,1,2,3.
- Reset asserted mid-BUSY: all outputs return to reset values on that edge, regardless of done or req.

## Timing
- Grant latency: if req is sampled nonzero in IDLE at edge k, gnt is valid after edge k.
- Release latency: if done or the owner's req drop is sampled at edge k, gnt=0 after edge k. The next grant is valid after edge k+1.
- Minimum grant width is 1 cycle (done asserted on the first BUSY cycle).
- Outputs are fully registered; there is no combinational path from req or done to any output.
- If done and the owner's req drop occur together, it is a single release, not a double event.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to BUSY and increments on each BUSY cycle.
  - When it reaches MAX_HOLD with no release, gnt=0, busy=0, timeout=1 for exactly one cycle, and the state goes to IDLE.
  - ptr keeps the revoked owner, so that owner has lowest priority at the next arbitration.
  - A normal release in the same cycle as the limit takes precedence: timeout stays 0.
- ARB_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0, and a grant is held indefinitely.

## Structure
- Package arb_pkg holds the state enum (IDLE, BUSY), N_REQ=4, ID_W=2, and the CNT_W=8 hold-counter width.
- Sub-module rr_pick: purely combinational. Inputs are req[3:0] and ptr[1:0]; outputs are win[1:0] and any. It rotates req, applies the fixed priority encode, then rotates the index back.
- The top level contains the FSM, the ptr register, the output registers and the optional counter.

## Test plan
- Reset, then req=0001: gnt=0001, gnt_id=0, busy=1 one cycle later. done=1 then gives gnt=0000 the next cycle.
- req=1111 held, with done pulsed on the first BUSY cycle of every grant: grant order is 0,1,2,3,0, each separated by one idle cycle.
- Owner 2 drops req without done while req=1100: gnt=0000 the next cycle, then gnt=1000 (id 3).
- After owner 3 releases with req=1001: next grant is 0 (wrap), not 3. A repeat release with req=1000 then grants 3.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=1010 held, no done: gnt=0010 for 4 cycles, then timeout pulses once with gnt=0000. The next grant is 1000.
- rst_n=0 during BUSY with gnt=0100: after that edge gnt=0000, busy=0, gnt_id=0. With req=1111 after reset release, the first grant is 0001.

Source files
------------

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the four-requester round-robin arbiter:
//   state_t - arbiter FSM states (IDLE, BUSY)
//   N_REQ   - number of requesters
//   ID_W    - width of the encoded owner index
//   CNT_W   - width of the hold counter built with ARB_TIMEOUT_EN
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational rotated priority encoder. The search starts at
// index ptr+1 and moves upward with wrap-around; the first set request wins.
// Ports:
//   req [3:0] in  - request vector
//   ptr [1:0] in  - index of the previous owner (lowest priority)
//   win [1:0] out - index of the winning requester (valid when any=1)
//   any       out - at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  win,
  output logic             any
);

  logic [ID_W-1:0]  start;
  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  off;

  always_comb begin
    start = ptr + 2'd1;
    // rot[0] is the highest-priority requester for this search
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[start + 2'(i)];
    end
    // Fixed priority encode: scan downward so the lowest set bit wins
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
    any = |req;
    // Rotate the offset back into an absolute index (wraps in 2 bits)
    win = start + off;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Four-requester round-robin arbiter. A registered one-hot grant and the
// encoded owner ID are held until the owner releases (done, or its request
// drops); priority then rotates past the last owner. Re-arbitration happens
// only in IDLE, so consecutive grants are separated by one idle cycle.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a hold counter revokes a grant after MAX_HOLD BUSY cycles
//   and pulses timeout for one cycle. When undefined, timeout is tied to 0
//   and grants are held indefinitely.
//
// Parameters:
//   MAX_HOLD - maximum consecutive BUSY cycles per grant (2..255)
// Ports:
//   clk        in  - rising-edge clock
//   rst_n      in  - synchronous active-low reset
//   req [3:0]  in  - level-sensitive request vector
//   done       in  - owner release strobe (meaningful while busy)
//   gnt [3:0]  out - registered one-hot grant, zero when idle
//   gnt_id[1:0]out - current/last owner index
//   busy       out - grant held
//   timeout    out - one-cycle pulse on hold-limit revocation
// -----------------------------------------------------------------------------
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic [ID_W-1:0]  win;
  logic             any;
  logic             release_c;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  // done and a dropped owner request collapse into one release event
  assign release_c = done | ~req[gnt_id_q];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any) begin
          gnt_d    = N_REQ'(1) << win;
          gnt_id_d = win;
          ptr_d    = win;
          busy_d   = 1'b1;
          state_d  = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      BUSY: begin
        if (release_c) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          // Counter value MAX_HOLD-1 marks the last allowed BUSY cycle;
          // ptr keeps the revoked owner so it drops to lowest priority.
          gnt_d     = '0;
          busy_d    = 1'b0;
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd3;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter4
// Directed testbench for rr_arbiter4 with a scoreboard queue of expected
// {gnt, gnt_id, busy, timeout} values, one entry per driven cycle.
// -----------------------------------------------------------------------------
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  rr_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, push the expected post-edge outputs, then
  // pop and compare once the edge has produced them.
  task automatic step(input logic rn, input logic [3:0] r, input logic d,
                      input logic [3:0] eg, input logic [1:0] eid,
                      input logic eb, input logic eto, input string tag);
    exp_t  e;
    exp_t  obs;
    string t;
    rst_n = rn;
    req   = r;
    done  = d;
    sb_q.push_back('{gnt: eg, id: eid, busy: eb, to: eto});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    t   = tag_q.pop_front();
    obs = '{gnt: gnt, id: gnt_id, busy: busy, to: timeout};
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed gnt=%b id=%0d busy=%b to=%b expected gnt=%b id=%0d busy=%b to=%b",
             t, obs.gnt, obs.id, obs.busy, obs.to, e.gnt, e.id, e.busy, e.to);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    @(negedge clk);

    // Reset state
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0, "reset0");
    step(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, "reset1");

    // Single requester grant and done release
    step(1, 4'b0001, 0, 4'b0001, 2'd0, 1, 0, "grant0");
    step(1, 4'b0001, 1, 4'b0000, 2'd0, 0, 0, "done0");

    // All requesting, done on first BUSY cycle: order 1,2,3,0 after 0
    step(1, 4'b1111, 1, 4'b0010, 2'd1, 1, 0, "rr_g1");
    step(1, 4'b1111, 1, 4'b0000, 2'd1, 0, 0, "rr_r1");
    step(1, 4'b1111, 1, 4'b0100, 2'd2, 1, 0, "rr_g2");
    step(1, 4'b1111, 1, 4'b0000, 2'd2, 0, 0, "rr_r2");
    step(1, 4'b1111, 1, 4'b1000, 2'd3, 1, 0, "rr_g3");
    step(1, 4'b1111, 1, 4'b0000, 2'd3, 0, 0, "rr_r3");
    step(1, 4'b1111, 1, 4'b0001, 2'd0, 1, 0, "rr_g0");
    step(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, "rr_r0");

    // Owner 2 drops its request without done
    step(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "drop_g2");
    step(1, 4'b1100, 0, 4'b0100, 2'd2, 1, 0, "drop_hold");
    step(1, 4'b1000, 0, 4'b0000, 2'd2, 0, 0, "drop_rel");
    step(1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, "drop_g3");

    // Wrap after owner 3 releases, then repeat release grants 3
    step(1, 4'b1001, 1, 4'b0000, 2'd3, 0, 0, "wrap_rel");
    step(1, 4'b1001, 0, 4'b0001, 2'd0, 1, 0, "wrap_g0");
    step(1, 4'b1001, 1, 4'b0000, 2'd0, 0, 0, "wrap_rel0");
    step(1, 4'b1000, 0, 4'b1000, 2'd3, 1, 0, "wrap_g3");

    // done together with request drop is a single release
    step(1, 4'b0000, 1, 4'b0000, 2'd3, 0, 0, "both_rel");
    step(1, 4'b0000, 0, 4'b0000, 2'd3, 0, 0, "idle_hold");

`ifdef ARB_TIMEOUT_EN
    // Hold limit of 4 cycles, then revocation and rotation past owner 1
    step(1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0, "to_g1");
    step(1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0, "to_h1");
    step(1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0, "to_h2");
    step(1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0, "to_h3");
    step(1, 4'b1010, 0, 4'b0000, 2'd1, 0, 1, "to_pulse");
    step(1, 4'b1010, 0, 4'b1000, 2'd3, 1, 0, "to_g3");
    // Release at the limit cycle takes precedence over timeout
    step(1, 4'b1010, 0, 4'b1000, 2'd3, 1, 0, "pr_h1");
    step(1, 4'b1010, 0, 4'b1000, 2'd3, 1, 0, "pr_h2");
    step(1, 4'b1010, 0, 4'b1000, 2'd3, 1, 0, "pr_h3");
    step(1, 4'b1010, 1, 4'b0000, 2'd3, 0, 0, "pr_rel");
`else
    // Without the hold limit the grant is held indefinitely
    step(1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0, "hold_g1");
    for (int i = 0; i < 10; i++) begin
      step(1, 4'b1010, 0, 4'b0010, 2'd1, 1, 0, "hold_long");
    end
    step(1, 4'b1010, 1, 4'b0000, 2'd1, 0, 0, "hold_rel");
`endif

    // Reset asserted mid-BUSY
    step(1, 4'b0100, 0, 4'b0100, 2'd2, 1, 0, "mid_g2");
    step(0, 4'b0100, 0, 4'b0000, 2'd0, 0, 0, "mid_rst");
    step(1, 4'b1111, 0, 4'b0001, 2'd0, 1, 0, "post_rst_g0");
    step(1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0, "post_rst_rel");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
